// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame scheduler and the transmitter it feeds.
// Frame layout: start bit, destination, data count, then the data bits LSB first.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_CNT,
    ST_DATA,
    ST_WAIT_DONE
  } state_t;

  localparam int ADDR_W   = 2;
  localparam int CNT_W    = 4;
  localparam int DATA_MAX = 16;

  localparam logic START_BIT  = 1'b0;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: combinational winner, registered search pointer.
// The search starts at the requester after the last one granted.
module rr_arbiter4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       grant_en,
  output logic [3:0] win_onehot,
  output logic [1:0] win_idx,
  output logic       any_req
);

  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  logic [1:0] cand;
  logic       found;

  always_comb begin
    win_idx = 2'd0;
    found   = 1'b0;
    cand    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && req[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end

  assign any_req = |req;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_onehot
      assign win_onehot[gi] = any_req && (win_idx == 2'(gi));
    end
  endgenerate

  always_comb begin
    ptr_d = ptr_q;
    if (grant_en && any_req) begin
      ptr_d = win_idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/serial_frame_scheduler.sv
// Shares one serial transmitter between four requesters: arbitrates, latches the
// winner's fields, serialises the frame and waits for the transmitter's Done.
module serial_frame_scheduler
  import serial_pkg::*;
#(
  parameter int DONE_TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clkEn,
  input  logic [3:0]  req,
  input  logic [7:0]  dst,
  input  logic [15:0] len,
  input  logic [63:0] data,
  input  logic        Done,
  output logic        SerOut,
  output logic [3:0]  gnt,
  output logic        busy,
  output logic        timeoutErr
);

  localparam int TMO_W = $clog2(DONE_TIMEOUT + 1);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     dst_q, dst_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [DATA_MAX-1:0]   data_q, data_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                  ser_out_q, ser_out_d;
  logic [3:0]            gnt_q, gnt_d;
  logic                  busy_q, busy_d;
  logic                  tmo_err_q, tmo_err_d;

  logic [ADDR_W-1:0]     dst_arr  [4];
  logic [CNT_W-1:0]      len_arr  [4];
  logic [DATA_MAX-1:0]   data_arr [4];

  logic [3:0]            win_onehot;
  logic [1:0]            win_idx;
  logic                  any_req;
  logic                  grant_fire;
  logic [1:0]            cnt_idx;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fields
      assign dst_arr[gi]  = dst[gi*ADDR_W +: ADDR_W];
      assign len_arr[gi]  = len[gi*CNT_W +: CNT_W];
      assign data_arr[gi] = data[gi*DATA_MAX +: DATA_MAX];
    end
  endgenerate

  assign grant_fire = clkEn && (state_q == ST_IDLE) && any_req;

  rr_arbiter4 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant_en   (grant_fire),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .any_req    (any_req)
  );

  // Count field goes out MSB first while bit_cnt runs upward.
  assign cnt_idx = 2'd2 - bit_cnt_q[1:0];

  always_comb begin
    state_d   = state_q;
    dst_d     = dst_q;
    len_d     = len_q;
    data_d    = data_q;
    bit_cnt_d = bit_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    ser_out_d = ser_out_q;
    gnt_d     = 4'd0;
    tmo_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ser_out_d = IDLE_LEVEL;
        if (grant_fire) begin
          dst_d     = dst_arr[win_idx];
          len_d     = len_arr[win_idx];
          data_d    = data_arr[win_idx];
          gnt_d     = win_onehot;
          bit_cnt_d = 4'd0;
          tmo_cnt_d = '0;
          ser_out_d = START_BIT;
          state_d   = ST_START;
        end
      end

      ST_START: begin
        if (clkEn) begin
          ser_out_d = dst_q[ADDR_W-1];
          bit_cnt_d = 4'd0;
          state_d   = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (clkEn) begin
          if (bit_cnt_q == 4'd0) begin
            ser_out_d = dst_q[0];
            bit_cnt_d = 4'd1;
          end else begin
            ser_out_d = len_q[CNT_W-1];
            bit_cnt_d = 4'd0;
            state_d   = ST_CNT;
          end
        end
      end

      ST_CNT: begin
        if (clkEn) begin
          if (bit_cnt_q < 4'd3) begin
            ser_out_d = len_q[cnt_idx];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (len_q == 4'd0) begin
            ser_out_d = IDLE_LEVEL;
            tmo_cnt_d = '0;
            state_d   = ST_WAIT_DONE;
          end else begin
            ser_out_d = data_q[0];
            bit_cnt_d = 4'd0;
            state_d   = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (clkEn) begin
          if (bit_cnt_q == (len_q - 4'd1)) begin
            ser_out_d = IDLE_LEVEL;
            tmo_cnt_d = '0;
            state_d   = ST_WAIT_DONE;
          end else begin
            ser_out_d = data_q[bit_cnt_q + 4'd1];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      ST_WAIT_DONE: begin
        ser_out_d = IDLE_LEVEL;
        // Done is honoured on every clk edge, not only enabled ones.
        if (Done) begin
          tmo_cnt_d = '0;
          state_d   = ST_IDLE;
        end else if (clkEn) begin
          if (tmo_cnt_q == TMO_W'(DONE_TIMEOUT - 1)) begin
            tmo_err_d = 1'b1;
            tmo_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
        end
      end

      default: begin
        ser_out_d = IDLE_LEVEL;
        state_d   = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dst_q     <= '0;
      len_q     <= '0;
      data_q    <= '0;
      bit_cnt_q <= 4'd0;
      tmo_cnt_q <= '0;
      ser_out_q <= IDLE_LEVEL;
      gnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      data_q    <= data_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      ser_out_q <= ser_out_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign SerOut     = ser_out_q;
  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign timeoutErr = tmo_err_q;

endmodule

// File: tb/tb_serial_frame_scheduler.sv
// Directed bench for serial_frame_scheduler: frame content, arbitration order,
// zero-length frames, Done timeout, enable gating and mid-frame reset.
module tb_serial_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        clkEn;
  logic [3:0]  req;
  logic [7:0]  dst;
  logic [15:0] len;
  logic [63:0] data;
  logic        Done;
  logic        SerOut;
  logic [3:0]  gnt;
  logic        busy;
  logic        timeoutErr;

  int tests_run    = 0;
  int tests_failed = 0;
  bit gate_mode    = 1'b0;
  int div          = 0;
  bit edge_en      = 1'b0;

  always #5 clk = ~clk;

  serial_frame_scheduler #(.DONE_TIMEOUT(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .clkEn      (clkEn),
    .req        (req),
    .dst        (dst),
    .len        (len),
    .data       (data),
    .Done       (Done),
    .SerOut     (SerOut),
    .gnt        (gnt),
    .busy       (busy),
    .timeoutErr (timeoutErr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge; edge_en tells whether the passed posedge was enabled.
  task automatic step();
    logic en_before;
    en_before = clkEn;
    @(negedge clk);
    edge_en = en_before;
    if (gate_mode) begin
      div   = (div == 2) ? 0 : div + 1;
      clkEn = (div == 0);
    end
  endtask

  task automatic wait_gnt(input string tag, input logic [3:0] exp_gnt);
    int waited;
    waited = 0;
    while (gnt == 4'd0 && waited < 60) begin
      step();
      waited++;
    end
    check({tag, " gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, " busy_at_gnt"}, 32'(busy), 32'd1);
  endtask

  task automatic expect_frame(input string tag, input logic [3:0] exp_gnt,
                              input logic [3:0] req_after, input string bits,
                              input int period, input bit scramble);
    int cnt;
    wait_gnt(tag, exp_gnt);
    req = req_after;
    if (scramble) begin
      dst  = ~dst;
      len  = ~len;
      data = ~data;
    end
    check({tag, " bit0"}, 32'(SerOut), 32'(bits[0] == 8'h31));
    for (int k = 1; k < bits.len(); k++) begin
      cnt = 0;
      do begin
        step();
        cnt++;
        if (!edge_en)
          check($sformatf("%s hold%0d", tag, k - 1), 32'(SerOut), 32'(bits[k-1] == 8'h31));
      end while (!edge_en && cnt < 10);
      check($sformatf("%s bitlen%0d", tag, k), 32'(cnt), 32'(period));
      check($sformatf("%s bit%0d", tag, k), 32'(SerOut), 32'(bits[k] == 8'h31));
    end
  endtask

  task automatic pulse_done(input string tag);
    Done = 1'b1;
    step();
    Done = 1'b0;
    check({tag, " busy_after_done"}, 32'(busy), 32'd0);
    check({tag, " idle_after_done"}, 32'(SerOut), 32'd1);
  endtask

  initial begin
    string rr_bits [4];
    int    n;
    rr_bits = '{"00000001", "00100001", "01000001", "01100001"};

    rst = 1'b1; clkEn = 1'b1; req = 4'd0; dst = 8'd0; len = 16'd0;
    data = 64'd0; Done = 1'b0;
    step();
    step();
    check("rst SerOut", 32'(SerOut), 32'd1);
    check("rst gnt", 32'(gnt), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst timeoutErr", 32'(timeoutErr), 32'd0);
    rst = 1'b0;
    step();

    // Single frame; upper data bits set to prove only len bits are sent.
    dst = 8'b0000_0011; len = 16'h0004; data = 64'h0000_0000_0000_FFF6;
    req = 4'b0001;
    expect_frame("single", 4'b0001, 4'b0000, "011010001101", 1, 1'b1);
    step();
    check("single busy_wait", 32'(busy), 32'd1);
    check("single gnt_pulse", 32'(gnt), 32'd0);
    pulse_done("single");

    rst = 1'b1;
    step();
    rst = 1'b0;

    dst = 8'b11_10_01_00; len = 16'h0000; data = 64'd0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      expect_frame($sformatf("rr%0d", i), 4'(1 << (i % 4)),
                   (i == 4) ? 4'b0000 : 4'b1111, rr_bits[i % 4], 1, 1'b0);
      pulse_done($sformatf("rr%0d", i));
    end

    // Pointer now at requester 1.
    dst = 8'b00_00_01_00; len = 16'h0000; req = 4'b0010;
    expect_frame("zero", 4'b0010, 4'b0000, "00100001", 1, 1'b0);
    check("zero busy_wait", 32'(busy), 32'd1);
    pulse_done("zero");

    dst = 8'b00_10_00_00; len = 16'h0000; req = 4'b0100;
    expect_frame("tmo", 4'b0100, 4'b0000, "01000001", 1, 1'b0);
    n = 0;
    while (!timeoutErr && n < 100) begin
      step();
      n++;
    end
    check("tmo cycles", 32'(n), 32'd32);
    check("tmo busy", 32'(busy), 32'd0);
    step();
    check("tmo pulse_width", 32'(timeoutErr), 32'd0);

    gate_mode = 1'b1; div = 0; clkEn = 1'b1;
    dst = 8'b11_00_00_00; len = 16'h4000; data = 64'hFFF6_0000_0000_0000;
    req = 4'b1000;
    expect_frame("gated", 4'b1000, 4'b0000, "011010001101", 3, 1'b0);
    pulse_done("gated");
    gate_mode = 1'b0; clkEn = 1'b1;
    step();

    dst = 8'b0000_0011; len = 16'h0004; data = 64'h0000_0000_0000_0006;
    req = 4'b0001;
    wait_gnt("mid", 4'b0001);
    repeat (8) step();
    check("mid data_bit1", 32'(SerOut), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid SerOut", 32'(SerOut), 32'd1);
    check("mid busy", 32'(busy), 32'd0);
    check("mid gnt", 32'(gnt), 32'd0);
    req = 4'b0011;
    wait_gnt("post_rst", 4'b0001);
    req = 4'b0000;
    repeat (12) step();
    pulse_done("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_frame_scheduler.md
# serial_frame_scheduler

Round-robin scheduler that shares the single serial transmitter channel between four local requesters. It accepts one frame request at a time, serialises it onto the transmitter's `SerIn` line, and waits for the transmitter's `Done` before granting the next requester. A frame is a start bit, a 2-bit destination port, a 4-bit data count and the data bits. The block sits directly upstream of the transmitter top level and reuses its `clk`/`clkEn` timebase.

## Interface
Parameters:
- `DONE_TIMEOUT`, 32: number of enabled cycles to wait for `Done` after the last frame bit before aborting.

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `clkEn`, input, 1: bit-rate enable; the FSM, counters and `SerOut` advance only on edges where `clkEn=1`.
- `req`, input, 4: request per requester; level-sensitive; must be held until the matching `gnt` is seen.
- `dst`, input, 8: destination port per requester; requester i uses `dst[2i+1:2i]`.
- `len`, input, 16: data-bit count 0..15 per requester; requester i uses `len[4i+3:4i]`.
- `data`, input, 64: payload per requester; requester i uses `data[16i+15:16i]`, of which only the low `len` bits are sent.
- `Done`, input, 1: frame-complete flag from the transmitter.
- `SerOut`, output, 1: serial line to the transmitter's `SerIn`; registered; idles at 1.
- `gnt`, output, 4: one-hot, one-`clk` pulse marking the cycle in which requester i's fields are latched.
- `busy`, output, 1: high in every state except IDLE.
- `timeoutErr`, output, 1: one-`clk` pulse when the `Done` wait expires.

## Operation
States: IDLE, START, ADDR, CNT, DATA, WAIT_DONE.

- **IDLE**
  - `SerOut=1`.
  - On an enabled cycle with `req!=0`: select the winner round-robin, beginning at the requester after the last granted one. After reset the search begins at requester 0.
  - Latch the winner's `dst`, `len` and `data`, pulse `gnt[i]`, update the round-robin pointer, and go to START.
- **START**: `SerOut=0` for one enabled cycle.
- **ADDR**: 2 bits, MSB first.
- **CNT**: 4 bits of `len`, MSB first.
  - If `len=0`, skip DATA and go straight to WAIT_DONE.
- **DATA**: `len` bits, LSB first (`data[0]` first), counted by a 4-bit bit counter.
- **WAIT_DONE**
  - `SerOut=1`.
  - A timeout counter increments on each enabled cycle.
  - `Done=1` sampled on any `clk` edge, regardless of `clkEn`: go to IDLE.
  - Counter reaches `DONE_TIMEOUT`: pulse `timeoutErr` and go to IDLE.
- **Field latching**: fields are latched at grant. Changes to the requester's inputs after grant do not affect the frame in flight.
- **Bits of `len`/`data` beyond `len`**: ignored.
- **Requests during a frame**: recorded only as `req` levels; they are arbitrated at the next IDLE enabled cycle.
- **Dropped request**: a requester that drops `req` before being granted loses its turn without error.
- **Frame length**: 7 + `len` bits.

## Timing
- **Reset values**: state=IDLE, `SerOut=1`, `gnt=0`, `busy=0`, `timeoutErr=0`, round-robin pointer selects requester 0 first, all counters 0.
- **`rst` priority**: `rst` overrides `clkEn` and aborts any frame mid-operation. `SerOut` returns to 1 on that edge and no `gnt` is issued.
- **`gnt` and `busy`**: assert on the same edge on which `SerOut` first drives the start bit 0. Both are registered with the state transition into START.
- **Bit durations**: each bit lasts exactly one enabled cycle, i.e. from one enabled edge to the next.
- **`clkEn=0`**: all outputs hold, except `gnt` and `timeoutErr`, which are single-`clk` pulses.
- **Minimum gap between frames**: one enabled cycle with `SerOut=1` (IDLE) between WAIT_DONE exit and the next start bit.

## Structure
- **Shared package `serial_pkg`**:
  - state enum;
  - field widths (`ADDR_W=2`, `CNT_W=4`, `DATA_MAX=16`);
  - `START_BIT=0` and `IDLE_LEVEL=1`.
  The transmitter and its testbench import the same package.
- **Sub-module `rr_arbiter4`**: combinational one-hot winner from `req` and the pointer, plus pointer update on grant.
- **Top level**: FSM, shift/bit counters and timeout counter.

## Test plan
- **Single frame**: with `clkEn=1` constant, `req=0001`, `dst[1:0]=2'b11`, `len[3:0]=4`, `data[3:0]=4'b0110`, then `Done` pulsed two cycles after the last bit.
  - Required `SerOut` sequence from the grant edge: 0, 1,1, 0,1,0,0, 0,1,1,0.
  - `gnt=0001` for one cycle; `busy` spans the frame through `Done`.
- **Round-robin**: `req=1111` held constantly, each `Done` answered promptly.
  - Grants must occur in order 0001, 0010, 0100, 1000, 0001.
- **Zero length**: `len=0`, `dst=2'b01`.
  - `SerOut` must be 0, 0,1, 0,0,0,0, then idle 1.
  - WAIT_DONE is entered directly after CNT.
- **Timeout**: `Done` held at 0 with `DONE_TIMEOUT=32`.
  - `timeoutErr` pulses exactly 32 enabled cycles after the last frame bit; state returns to IDLE.
- **Enable gating**: `clkEn` toggled 1-of-3 cycles.
  - Each bit is held for 3 `clk` cycles; frame content is identical to the single-frame case.
- **Mid-frame reset**: `rst` asserted for one cycle during DATA.
  - Next edge: `SerOut=1`, `busy=0`.
  - The next grant goes to requester 0.
